// File: rtl/spi_mem_pkg.sv
// Shared opcodes and controller state encoding for the SPI serial-SRAM responder.
package spi_mem_pkg;

   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_WRITE = 8'h02;
   localparam logic [7:0] OP_RDSR  = 8'h05;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_READ,
      ST_WRITE,
      ST_STATUS,
      ST_IGNORE
   } state_t;

endpackage

// File: rtl/spi_mem_responder_sync.sv
// Brings the asynchronous SPI pins into the clk domain and flags SCLK edges.
module spi_pin_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic sclk_in,
   input  logic cs_n_in,
   input  logic mosi_in,
   output logic cs_n_sync,
   output logic mosi_sync,
   output logic rise,
   output logic fall
);

   logic [1:0] sclk_ff;
   logic [1:0] cs_ff;
   logic [1:0] mosi_ff;
   logic       sclk_prev;

   // CS resets to "selected" so a select held across reset never looks like a fresh one.
   // The third stage keeps CS/MOSI aligned with the registered edge pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_ff   <= 2'b00;
         cs_ff     <= 2'b00;
         mosi_ff   <= 2'b00;
         sclk_prev <= 1'b0;
         rise      <= 1'b0;
         fall      <= 1'b0;
         cs_n_sync <= 1'b0;
         mosi_sync <= 1'b0;
      end else begin
         sclk_ff   <= {sclk_ff[0], sclk_in};
         cs_ff     <= {cs_ff[0], cs_n_in};
         mosi_ff   <= {mosi_ff[0], mosi_in};
         sclk_prev <= sclk_ff[1];
         rise      <= sclk_ff[1] & ~sclk_prev;
         fall      <= ~sclk_ff[1] & sclk_prev;
         cs_n_sync <= cs_ff[1];
         mosi_sync <= mosi_ff[1];
      end
   end

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 target emulating a small serial SRAM (READ / WRITE / RDSR).
module spi_mem_responder
   import spi_mem_pkg::*;
#(
   parameter int          DEPTH     = 16,
   parameter logic [7:0]  STATUS_ID = 8'hA5,
   localparam int         AW        = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          sclk_in,
   input  logic          cs_n_in,
   input  logic          mosi_in,
   output logic          miso_out,
   output logic          miso_oe_out,
   output logic          wr_pulse_out,
   output logic [AW-1:0] wr_addr_out,
   output logic [7:0]    wr_data_out
);

   state_t        state_q;
   state_t        state_d;
   logic          cs_n_sync;
   logic          mosi_sync;
   logic          rise;
   logic          fall;
   logic [2:0]    bit_cnt;
   logic [1:0]    addr_cnt;
   logic [7:0]    rx_shift;
   logic [7:0]    rx_next;
   logic [7:0]    tx_shift;
   logic          byte_done;
   logic [AW-1:0] addr;
   logic [AW-1:0] addr_inc;
   logic          rd_cmd;
   logic          seen_high;
   logic          mem_we;
   logic [7:0]    mem [DEPTH];

   spi_pin_sync u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .sclk_in   (sclk_in),
      .cs_n_in   (cs_n_in),
      .mosi_in   (mosi_in),
      .cs_n_sync (cs_n_sync),
      .mosi_sync (mosi_sync),
      .rise      (rise),
      .fall      (fall)
   );

   assign rx_next   = {rx_shift[6:0], mosi_sync};
   assign byte_done = rise && (bit_cnt == 3'd7);
   assign addr_inc  = addr + AW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // A deasserted CS overrides everything, including a byte completing in the same cycle.
   always_comb begin
      state_d = state_q;
      mem_we  = 1'b0;
      if (cs_n_sync) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  if (seen_high) state_d = ST_CMD;
            ST_CMD:
               if (byte_done) begin
                  if (rx_next == OP_READ || rx_next == OP_WRITE) state_d = ST_ADDR;
                  else if (rx_next == OP_RDSR)                   state_d = ST_STATUS;
                  else                                           state_d = ST_IGNORE;
               end
            ST_ADDR:
               if (byte_done && addr_cnt == 2'd2) state_d = rd_cmd ? ST_READ : ST_WRITE;
            ST_WRITE: mem_we = byte_done;
            default:  ;
         endcase
      end
   end

   // Bit/byte bookkeeping, TX shifter and the write strobe; seen_high gates selection after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt      <= '0;
         addr_cnt     <= '0;
         rx_shift     <= '0;
         tx_shift     <= '0;
         addr         <= '0;
         rd_cmd       <= 1'b0;
         seen_high    <= 1'b0;
         miso_out     <= 1'b0;
         miso_oe_out  <= 1'b0;
         wr_pulse_out <= 1'b0;
         wr_addr_out  <= '0;
         wr_data_out  <= '0;
      end else begin
         wr_pulse_out <= 1'b0;
         if (cs_n_sync) begin
            seen_high   <= 1'b1;
            bit_cnt     <= '0;
            addr_cnt    <= '0;
            rx_shift    <= '0;
            miso_out    <= 1'b0;
            miso_oe_out <= 1'b0;
         end else if (state_q != ST_IDLE) begin
            if (rise) begin
               bit_cnt  <= bit_cnt + 3'd1;
               rx_shift <= rx_next;
            end
            if (fall && (state_q == ST_READ || state_q == ST_STATUS)) begin
               miso_out    <= tx_shift[7];
               tx_shift    <= {tx_shift[6:0], 1'b0};
               miso_oe_out <= 1'b1;
            end
            case (state_q)
               ST_CMD:
                  if (byte_done) begin
                     rd_cmd   <= (rx_next == OP_READ);
                     tx_shift <= STATUS_ID;
                  end
               ST_ADDR:
                  if (byte_done) begin
                     addr     <= rx_next[AW-1:0];
                     addr_cnt <= addr_cnt + 2'd1;
                     tx_shift <= mem[rx_next[AW-1:0]];
                  end
               ST_READ:
                  if (byte_done) begin
                     addr     <= addr_inc;
                     tx_shift <= mem[addr_inc];
                  end
               ST_STATUS:
                  if (byte_done) tx_shift <= STATUS_ID;
               ST_WRITE:
                  if (byte_done) begin
                     wr_pulse_out <= 1'b1;
                     wr_addr_out  <= addr;
                     wr_data_out  <= rx_next;
                     addr         <= addr_inc;
                  end
               default: ;
            endcase
         end
      end
   end

   // Storage is deliberately unreset so contents survive CS cycles like a real SRAM.
   always_ff @(posedge clk) begin
      if (mem_we) mem[addr] <= rx_next;
   end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Scoreboard bench: a behavioural SRAM model predicts write strobes and read bytes for the responder.
module tb_spi_mem_responder;

   localparam int DEPTH = 16;
   localparam int HALF  = 10;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       sclk_in = 1'b0;
   logic       cs_n_in = 1'b1;
   logic       mosi_in = 1'b0;
   logic       miso_out;
   logic       miso_oe_out;
   logic       wr_pulse_out;
   logic [3:0] wr_addr_out;
   logic [7:0] wr_data_out;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t        exp_wr[$];
   logic [7:0] exp_rd[$];
   logic [7:0] ref_mem [DEPTH];
   wr_t        wr_e;
   logic [7:0] mon_sh = 8'h00;
   int         mon_cnt = 0;

   spi_mem_responder #(.DEPTH(DEPTH), .STATUS_ID(8'hA5)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sclk_in      (sclk_in),
      .cs_n_in      (cs_n_in),
      .mosi_in      (mosi_in),
      .miso_out     (miso_out),
      .miso_oe_out  (miso_oe_out),
      .wr_pulse_out (wr_pulse_out),
      .wr_addr_out  (wr_addr_out),
      .wr_data_out  (wr_data_out)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Write monitor: every strobe cycle must match the next predicted (addr, data).
   always @(negedge clk) begin
      if (wr_pulse_out === 1'b1) begin
         if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_write actual=%0h:%0h expected=none", wr_addr_out, wr_data_out);
         end else begin
            wr_e = exp_wr.pop_front();
            check_output("wr_addr", 32'(wr_addr_out), 32'(wr_e.addr));
            check_output("wr_data", 32'(wr_data_out), 32'(wr_e.data));
         end
      end
   end

   // Read monitor: samples MISO like the master, on SCLK rise while the output is enabled.
   always @(posedge sclk_in or posedge cs_n_in or negedge rst_n) begin
      if (!rst_n || cs_n_in) begin
         mon_cnt = 0;
      end else if (miso_oe_out === 1'b1) begin
         mon_sh = {mon_sh[6:0], miso_out};
         mon_cnt++;
         if (mon_cnt == 8) begin
            mon_cnt = 0;
            if (exp_rd.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_read actual=%0h expected=none", mon_sh);
            end else begin
               check_output("rd_byte", 32'(mon_sh), 32'(exp_rd.pop_front()));
            end
         end
      end
   end

   task automatic half_period();
      repeat (HALF) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      mosi_in = b;
      half_period();
      sclk_in = 1'b1;
      half_period();
      sclk_in = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic cs_begin();
      cs_n_in = 1'b0;
      half_period();
   endtask

   task automatic cs_end();
      half_period();
      cs_n_in = 1'b1;
      repeat (2 * HALF) @(posedge clk);
      #1;
   endtask

   task automatic send_header(input logic [7:0] op, input logic [23:0] a);
      send_byte(op);
      send_byte(a[23:16]);
      send_byte(a[15:8]);
      send_byte(a[7:0]);
   endtask

   // Data bytes are taken MSB-first from 'data'; the model memory tracks each commit.
   task automatic apply_write(input logic [23:0] a, input int n, input logic [31:0] data);
      int         idx;
      logic [7:0] b;
      idx = int'(a % DEPTH);
      cs_begin();
      send_header(8'h02, a);
      for (int k = 0; k < n; k++) begin
         b = data[31 - 8 * k -: 8];
         exp_wr.push_back('{addr: 4'(idx), data: b});
         ref_mem[idx] = b;
         idx = (idx + 1) % DEPTH;
         send_byte(b);
      end
      cs_end();
   endtask

   task automatic apply_read(input logic [23:0] a, input int n);
      int idx;
      idx = int'(a % DEPTH);
      cs_begin();
      send_header(8'h03, a);
      for (int k = 0; k < n; k++) begin
         exp_rd.push_back(ref_mem[idx]);
         idx = (idx + 1) % DEPTH;
         send_byte(8'($urandom));
      end
      cs_end();
   endtask

   task automatic apply_rdsr(input int n);
      logic [7:0] op;
      op = 8'h05;
      cs_begin();
      for (int i = 7; i >= 1; i--) send_bit(op[i]);
      check_output("rdsr_oe_opcode", 32'(miso_oe_out), 32'd0);
      send_bit(op[0]);
      for (int k = 0; k < n; k++) begin
         exp_rd.push_back(8'hA5);
         send_byte(8'($urandom));
      end
      check_output("rdsr_oe_data", 32'(miso_oe_out), 32'd1);
      cs_end();
      check_output("rdsr_oe_after_cs", 32'(miso_oe_out), 32'd0);
   endtask

   task automatic apply_unknown(input logic [7:0] op, input int n);
      cs_begin();
      send_byte(op);
      for (int k = 0; k < n; k++) begin
         send_byte(8'($urandom));
         check_output("unknown_oe", 32'(miso_oe_out), 32'd0);
      end
      cs_end();
   endtask

   initial begin
      #950000;
      $display("[TB] FAIL timeout actual=running expected=finished");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      logic [7:0] b;
      int         sel;
      repeat (4) @(posedge clk);
      #1;
      check_output("reset_miso", 32'(miso_out), 32'd0);
      check_output("reset_oe", 32'(miso_oe_out), 32'd0);
      check_output("reset_wr_pulse", 32'(wr_pulse_out), 32'd0);
      check_output("reset_wr_addr", 32'(wr_addr_out), 32'd0);
      check_output("reset_wr_data", 32'(wr_data_out), 32'd0);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;

      $display("[TB] write/read at 3");
      apply_write(24'h000003, 2, 32'h1122_0000);
      apply_read(24'h000003, 2);

      $display("[TB] wrap-around write/read");
      apply_write(24'h00000F, 2, 32'hAABB_0000);
      apply_read(24'h0000FF, 2);

      $display("[TB] status read");
      apply_rdsr(3);

      $display("[TB] unknown opcode");
      apply_unknown(8'h9F, 2);

      $display("[TB] partial write byte");
      cs_begin();
      send_header(8'h02, 24'h000000);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      cs_end();
      apply_read(24'h000000, 1);

      $display("[TB] reset during read");
      cs_begin();
      send_header(8'h03, 24'h000003);
      exp_rd.push_back(ref_mem[3]);
      send_byte(8'h00);
      for (int i = 0; i < 3; i++) send_bit(1'b0);
      rst_n = 1'b0;
      #1;
      check_output("midreset_oe", 32'(miso_oe_out), 32'd0);
      check_output("midreset_miso", 32'(miso_out), 32'd0);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b1;
      half_period();
      send_header(8'h03, 24'h000003);
      send_byte(8'h00);
      check_output("post_reset_oe", 32'(miso_oe_out), 32'd0);
      cs_end();
      apply_read(24'h000003, 2);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 4; i++) apply_write(24'(i * 4), 4, $urandom);
      for (int t = 0; t < 16; t++) begin
         sel = int'($urandom_range(0, 3));
         case (sel)
            0: apply_write(24'($urandom), int'($urandom_range(1, 4)), $urandom);
            1: apply_read(24'($urandom), int'($urandom_range(1, 4)));
            2: apply_rdsr(int'($urandom_range(1, 2)));
            default: begin
               b = 8'($urandom);
               if (b == 8'h02 || b == 8'h03 || b == 8'h05) b = 8'h9F;
               apply_unknown(b, 1);
            end
         endcase
      end

      repeat (50) @(posedge clk);
      #1;
      check_output("pending_writes", 32'(exp_wr.size()), 32'd0);
      check_output("pending_reads", 32'(exp_rd.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_mem_responder.md
# spi_mem_responder

SPI mode-0 target that emulates a small serial SRAM on the peripheral SPI bus: it accepts READ, WRITE and RDSR commands and serves them from an internal byte array. The block is the responder end of the peripheral SPI master (`periph_spi_sclk/mosi/cs`). It is used on-die as a loopback target and in benches as a synthesizable memory model. All SPI pins are oversampled in the system clock domain; there is no second clock.

## Interface
- `DEPTH`, 16: bytes of storage; power of two, 2..256.
- `STATUS_ID`, 8'hA5: byte returned by RDSR.
- `clk`  in  1  system clock; SCLK must be ≤ clk/10.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sclk_in`  in  1  SPI clock from master, asynchronous.
- `cs_n_in`  in  1  chip select, active low, asynchronous.
- `mosi_in`  in  1  master-out data, asynchronous.
- `miso_out`  out  1  target-out data.
- `miso_oe_out`  out  1  MISO output enable; high only while returning data.
- `wr_pulse_out`  out  1  one-clk strobe per committed write byte.
- `wr_addr_out`  out  $clog2(DEPTH)  address of committed byte.
- `wr_data_out`  out  8  value of committed byte.

## Operation
- Synchronize `sclk_in`, `cs_n_in` and `mosi_in` through 2-FF synchronizers. Derive `rise`/`fall` pulses from the synchronized SCLK and the previous-cycle SCLK.
- Shift MOSI MSB-first on `rise`. A 3-bit bit counter completes a byte on the 8th `rise`.
- FSM states:
  - IDLE: wait for synchronized CS low, then go to CMD.
  - CMD: on byte complete, decode: 0x03 → ADDR (read), 0x02 → ADDR (write), 0x05 → STATUS. Any other opcode → IGNORE.
  - ADDR: receive 3 bytes (24-bit address, MSB first). Keep the low $clog2(DEPTH) bits; ignore upper bits. After byte 3, go to READ or WRITE.
  - READ: on entry, load `mem[addr]` into the TX shifter. On every `fall`, present the next bit on MISO. On byte complete, increment addr modulo DEPTH and reload.
  - WRITE: on byte complete, write `mem[addr]`, pulse `wr_*`, increment addr modulo DEPTH.
  - STATUS: return `STATUS_ID` repeatedly.
  - IGNORE: discard all bits until CS deasserts.
- Synchronized CS high in any state: go to IDLE within 1 clk. Clear bit and byte counters, drop `miso_oe_out`, and discard any partial byte; a partial write byte is never committed.
- Memory contents persist across CS transactions and are not reset (X until written).

## Timing
- Reset values: `miso_out`=0, `miso_oe_out`=0, `wr_pulse_out`=0, `wr_addr_out`=0, `wr_data_out`=0, state IDLE, counters 0.
- Input edge to internal `rise`/`fall` pulse: 3 clk.
- MISO update: registered 1 clk after `fall` (4 clk after the pin edge). Valid before the master's next rising edge when SCLK ≤ clk/10.
- Read path: bit 7 of the first data byte is driven on the `fall` that follows the 32nd `rise`. `miso_oe_out` rises on that same cycle and stays high until CS high.
- Write path: `wr_pulse_out` is high for exactly the clk after the 8th `rise` of each data byte. It carries the pre-increment address.
- Address wraps from DEPTH-1 to 0 in both READ and WRITE.
- CS rise coincident with a `rise` that would complete a byte: CS wins, and the byte is discarded.
- Reset asserted mid-transaction: all outputs take reset values immediately. After reset releases with CS still low, the block stays in IDLE until CS deasserts and reasserts.

## Structure
- Shared package `spi_mem_pkg`: opcode constants (`OP_READ`=8'h03, `OP_WRITE`=8'h02, `OP_RDSR`=8'h05) and the FSM state enum.
- One sub-module, `spi_pin_sync`: 2-FF synchronizer plus edge detect, producing synchronized CS, MOSI, `rise` and `fall`. Instantiated once.
- Storage is a plain register array inferred in the top module.

## Test plan
- WRITE 0x02, addr 0x000003, data 0x11 0x22 → `wr_pulse_out` twice, with (3, 0x11) then (4, 0x22). A subsequent READ 0x03 at addr 3 returns 0x11 0x22.
- WRITE at addr 0x00000F (DEPTH=16), data 0xAA 0xBB → writes land at addr 15 and addr 0. A READ at addr 0x0000FF returns 0xAA, then 0xBB (wrap).
- RDSR 0x05, clock 3 bytes → 0xA5 0xA5 0xA5. `miso_oe_out` is low during the opcode and high after.
- Unknown opcode 0x9F followed by 16 clocks → no `wr_pulse_out`, and `miso_oe_out` stays 0 throughout.
- WRITE 0x02, addr 0, then 5 data bits and CS high → no write pulse, and mem[0] is unchanged on readback.
- Reset pulse during a READ data byte → `miso_oe_out` goes to 0 at once. No response until CS toggles. A fresh READ afterwards returns the stored data.
